// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero skips the iteration and reports all-ones quotient with div_by_zero set.
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int unsigned PR_W  = DIVISOR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [DIVIDEND_W-1:0] dvd, dvd_nx;
  logic [DIVISOR_W-1:0]  dvs, dvs_nx;
  logic [PR_W-1:0]       prem, prem_nx;
  logic                  busy_nx, done_nx, dbz_nx;
  logic [DIVIDEND_W-1:0] quotient_nx;
  logic [DIVISOR_W-1:0]  remainder_nx;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  logic [PR_W-1:0]       shifted, diff, prem_step;
  logic                  borrow, qbit;
  logic [DIVIDEND_W-1:0] dvd_step;

  always_comb begin
    shifted        = PR_W'({prem, dvd[DIVIDEND_W-1]});
    {borrow, diff} = {1'b0, shifted} - {2'b00, dvs};
    qbit           = ~borrow;
    prem_step      = borrow ? shifted : diff;
    dvd_step       = {dvd[DIVIDEND_W-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      dvd         <= dvd_nx;
      dvs         <= dvs_nx;
      prem        <= prem_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      quotient    <= quotient_nx;
      remainder   <= remainder_nx;
      div_by_zero <= dbz_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    dvd_nx       = dvd;
    dvs_nx       = dvs;
    prem_nx      = prem;
    busy_nx      = busy;
    done_nx      = 1'b0;
    quotient_nx  = quotient;
    remainder_nx = remainder;
    dbz_nx       = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          dvd_nx   = dividend;
          dvs_nx   = divisor;
          prem_nx  = '0;
          cnt_nx   = CNT_W'(DIVIDEND_W);
          dbz_nx   = 1'b0;
          busy_nx  = 1'b1;
          state_nx = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        dvd_nx  = dvd_step;
        prem_nx = prem_step;
        cnt_nx  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx     = DONE;
          done_nx      = 1'b1;
          quotient_nx  = dvd_step;
          remainder_nx = DIVISOR_W'(prem_step);
        end
      end
      DONE: begin
        // Normal runs arrive with done already raised; a zero divisor raises it here.
        if (done) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          done_nx      = 1'b1;
          quotient_nx  = '1;
          remainder_nx = '0;
          dbz_nx       = 1'b1;
          cnt_nx       = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule
